spi_rx_framed: RTL and testbench

SPI_RX_FRAMED -- requirements
Module: spi_rx_framed

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_rx_framed_if.sv | 11 +
 rtl/spi_rx_fifo.sv | 52 +++++
 rtl/spi_rx_framed.sv | 167 ++++++++++++++++
 tb/tb_spi_rx_framed.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode/state typedefs and constant helpers that derive
// clock polarity, phase and sampling edge from an SPI mode number.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } spi_state_t;

  function automatic logic spi_cpol(input int mode);
    return ((mode >> 1) & 1) != 0;
  endfunction

  function automatic logic spi_cpha(input int mode);
    return (mode & 1) != 0;
  endfunction

  // Data is sampled on the rising sclk edge when polarity and phase agree.
  function automatic logic spi_sample_rising(input int mode);
    return spi_cpol(mode) == spi_cpha(mode);
  endfunction

endpackage

// File: rtl/spi_rx_framed_if.sv
// Word stream leaving the SPI receiver.
// A beat transfers on a clk edge where tvalid && tready; while tvalid is high and
// tready low, tdata holds stable and tvalid stays high until the beat is taken.
interface spi_rx_framed_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous word FIFO with occupancy level; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module spi_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];
  assign level     = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/spi_rx_framed.sv
// SPI slave receiver: synchronises sclk/mosi/cs_n into clk, assembles words
// inside cs_n frames, buffers them in a FIFO and flags overrun/framing errors.
module spi_rx_framed
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SPI_MODE    = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sclk,
  input  logic                              mosi,
  input  logic                              cs_n,
  spi_rx_framed_if.master                   m_axis,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy,
  output logic                              overrun_error,
  output logic                              frame_error,
  input  logic                              err_clear,
  output spi_state_t                        state_dbg
);

  localparam logic CPOL        = spi_cpol(SPI_MODE);
  localparam logic SAMPLE_RISE = spi_sample_rising(SPI_MODE);
  localparam int   CW          = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_prev;
  logic                   edge_c;
  logic                   sample_q;
  logic                   mosi_q;
  logic [2:0]             warm_cnt;
  logic                   warm;

  spi_state_t             state;
  spi_state_t             state_next;

  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  word_next;
  logic                   take;
  logic                   last_bit;
  logic                   end_frame;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overrun_evt;
  logic                   frame_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign edge_c = SAMPLE_RISE ? (sclk_s && !sclk_prev) : (!sclk_s && sclk_prev);

  // The synchroniser's reset value reads as cs_n high; wait until it holds real
  // samples so a frame interrupted by reset is not mistaken for a fresh one.
  assign warm = (warm_cnt == 3'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev <= CPOL;
      sample_q  <= 1'b0;
      mosi_q    <= 1'b0;
      warm_cnt  <= '0;
    end else begin
      sclk_prev <= sclk_s;
      sample_q  <= edge_c;
      mosi_q    <= mosi_s;
      if (!warm) warm_cnt <= warm_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_IDLE: if (warm && cs_s) state_next = ST_IDLE;
      ST_IDLE:      if (!cs_s)        state_next = ST_ACTIVE;
      ST_ACTIVE:    if (cs_s)         state_next = ST_IDLE;
      default:                        state_next = ST_WAIT_IDLE;
    endcase
  end

  assign take      = (state == ST_ACTIVE) && !cs_s && sample_q;
  assign end_frame = (state == ST_ACTIVE) && cs_s;
  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH-1));
  assign push      = take && last_bit;
  assign frame_evt = end_frame && (bit_cnt != '0);

  always_comb begin
    word_next = shift_reg;
    if (MSB_FIRST != 0) word_next = {shift_reg[DATA_WIDTH-2:0], mosi_q};
    else                word_next = {mosi_q, shift_reg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state != ST_ACTIVE || end_frame) begin
      bit_cnt <= '0;
    end else if (take) begin
      shift_reg <= word_next;
      bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  assign pop         = m_axis.tvalid && m_axis.tready;
  assign overrun_evt = push && fifo_full && !pop;

  spi_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_next),
    .pop       (pop),
    .head_data (m_axis.tdata),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis.tvalid = !fifo_empty;

  // A new error event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      overrun_error <= (overrun_error && !err_clear) || overrun_evt;
      frame_error   <= (frame_error && !err_clear) || frame_evt;
    end
  end

  assign busy      = (state == ST_ACTIVE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_rx_framed.sv
// Bench for spi_rx_framed: five instances cover modes 0..3 MSB-first and mode 0
// LSB-first; a word-level model predicts beats, level and error flags.
module tb_spi_rx_framed;
  import spi_pkg::*;

  localparam int N     = 5;
  localparam int H     = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sclk_v [N];
  logic       mosi_v [N];
  logic       cs_v   [N];
  logic       tready_v [N];
  logic       clr_v  [N];
  logic [7:0] tdata_a [N];
  logic       tvalid_v [N];
  logic [2:0] level_a [N];
  logic       busy_v [N];
  logic       ovr_v  [N];
  logic       ferr_v [N];
  spi_state_t st_a   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_rx_framed_if #(.DATA_WIDTH(8)) axis ();
    assign axis.tready   = tready_v[g];
    assign tdata_a[g]    = axis.tdata;
    assign tvalid_v[g]   = axis.tvalid;

    spi_rx_framed #(
      .DATA_WIDTH  (8),
      .SPI_MODE    ((g < 4) ? g : 0),
      .MSB_FIRST   ((g < 4) ? 1 : 0),
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (2)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .sclk          (sclk_v[g]),
      .mosi          (mosi_v[g]),
      .cs_n          (cs_v[g]),
      .m_axis        (axis),
      .fifo_level    (level_a[g]),
      .busy          (busy_v[g]),
      .overrun_error (ovr_v[g]),
      .frame_error   (ferr_v[g]),
      .err_clear     (clr_v[g]),
      .state_dbg     (st_a[g])
    );
  end

  // ---------------- scoreboard / model ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  acc   [N];
  int          nbits [N];
  bit          armed [N];
  bit          active[N];
  bit          m_ovr [N];
  bit          m_ferr[N];
  int          beats [N];
  logic [7:0]  last_data [N];
  bit          lat_armed = 1'b0;
  int          push_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tb_mode(input int i);
    return (i < 4) ? i : 0;
  endfunction

  function automatic int occupancy(input int i);
    int occ = 0;
    foreach (exp_q[j]) if (exp_q[j][10:8] == 3'(i)) occ++;
    return occ;
  endfunction

  task automatic model_bit(input int i, input logic b);
    logic [7:0] w;
    if (!active[i]) return;
    acc[i] = {acc[i][6:0], b};
    nbits[i]++;
    if (nbits[i] == 8) begin
      nbits[i] = 0;
      w = acc[i];
      if (i == 4) for (int k = 0; k < 8; k++) w[k] = acc[i][7-k];
      if (occupancy(i) < DEPTH) begin
        exp_q.push_back({3'(i), w});
        if (lat_armed) push_cyc = cyc;
      end else begin
        m_ovr[i] = 1'b1;
      end
    end
  endtask

  // Every accepted beat is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (tvalid_v[i] && tready_v[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_beat_dut%0d", i), {24'd0, tdata_a[i]}, 32'hFFFF_FFFF);
          end else begin
            check($sformatf("beat_dut%0d", i), {21'd0, 3'(i), tdata_a[i]}, {21'd0, exp_q[0]});
            void'(exp_q.pop_front());
          end
          if (lat_armed && i == 0) begin
            check("latency_edge_to_tvalid", cyc - push_cyc, 4);
            lat_armed = 1'b0;
          end
          beats[i]++;
          last_data[i] = tdata_a[i];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int i);
    cs_v[i]   = 1'b0;
    active[i] = armed[i];
    nbits[i]  = 0;
    waitn(H);
  endtask

  task automatic cs_high(input int i);
    waitn(H);
    cs_v[i] = 1'b1;
    if (active[i] && nbits[i] != 0) m_ferr[i] = 1'b1;
    nbits[i]  = 0;
    active[i] = 1'b0;
    armed[i]  = 1'b1;
    waitn(2*H);
  endtask

  // Sends seq[n-1] first on the wire.
  task automatic send_bits(input int i, input logic [31:0] seq, input int n);
    logic cpol, cpha;
    cpol = ((tb_mode(i) >> 1) & 1) != 0;
    cpha = (tb_mode(i) & 1) != 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (!cpha) begin
        mosi_v[i] = seq[k];
        waitn(H);
        sclk_v[i] = !cpol;
        model_bit(i, seq[k]);
        waitn(H);
        sclk_v[i] = cpol;
      end else begin
        sclk_v[i] = !cpol;
        mosi_v[i] = seq[k];
        waitn(H);
        sclk_v[i] = cpol;
        model_bit(i, seq[k]);
        waitn(H);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    waitn(3);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      armed[i] = cs_v[i]; active[i] = 1'b0; nbits[i] = 0;
      m_ovr[i] = 1'b0; m_ferr[i] = 1'b0;
    end
    waitn(4);
  endtask

  task automatic pulse_clear(input int i);
    clr_v[i] = 1'b1;
    waitn(1);
    clr_v[i] = 1'b0;
    m_ovr[i] = 1'b0; m_ferr[i] = 1'b0;
    waitn(2);
  endtask

  task automatic check_flags(input int i, input string tag);
    check($sformatf("%s_level", tag),   32'(level_a[i]), 32'(occupancy(i)));
    check($sformatf("%s_overrun", tag), 32'(ovr_v[i]),   32'(m_ovr[i]));
    check($sformatf("%s_frame", tag),   32'(ferr_v[i]),  32'(m_ferr[i]));
    check($sformatf("%s_busy", tag),    32'(busy_v[i]),  32'(active[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    for (int i = 0; i < N; i++) begin
      sclk_v[i] = ((tb_mode(i) >> 1) & 1) != 0;
      mosi_v[i] = 1'b0; cs_v[i] = 1'b1; tready_v[i] = 1'b1; clr_v[i] = 1'b0;
      acc[i] = '0; nbits[i] = 0; armed[i] = 1'b1; active[i] = 1'b0;
      m_ovr[i] = 1'b0; m_ferr[i] = 1'b0; beats[i] = 0; last_data[i] = '0;
    end

    // Reset values while rst is held.
    waitn(3);
    check("rst_tvalid",  32'(tvalid_v[0]), 0);
    check("rst_level",   32'(level_a[0]),  0);
    check("rst_busy",    32'(busy_v[0]),   0);
    check("rst_overrun", 32'(ovr_v[0]),    0);
    check("rst_frame",   32'(ferr_v[0]),   0);
    check("rst_state",   32'(st_a[0]),     32'(ST_WAIT_IDLE));
    rst = 1'b0;
    waitn(6);
    check("idle_state_after_rst", 32'(st_a[0]), 32'(ST_IDLE));

    // Mode 0, single byte 0xA5, with latency measured on the last bit.
    cs_low(0);
    check("busy_in_frame", 32'(busy_v[0]), 1);
    check("state_active", 32'(st_a[0]), 32'(ST_ACTIVE));
    lat_armed = 1'b1;
    send_bits(0, 32'hA5, 8);
    cs_high(0);
    check("a5_beats", 32'(beats[0]), 1);
    check("a5_data",  32'(last_data[0]), 32'hA5);
    check_flags(0, "a5");

    // Modes 1..3: two bytes back-to-back in one frame.
    for (int m = 1; m < 4; m++) begin
      cs_low(m);
      send_bits(m, 32'h3C, 8);
      send_bits(m, 32'hC3, 8);
      cs_high(m);
      check($sformatf("mode%0d_beats", m), 32'(beats[m]), 2);
      check($sformatf("mode%0d_last", m),  32'(last_data[m]), 32'hC3);
      check_flags(m, $sformatf("mode%0d", m));
    end

    // LSB-first: wire order 1,0,0,0,0,0,0,0.
    cs_low(4);
    send_bits(4, 32'h80, 8);
    cs_high(4);
    check("lsb_beats", 32'(beats[4]), 1);
    check("lsb_data",  32'(last_data[4]), 32'h01);

    // Overrun: six bytes with the sink stalled.
    b0 = beats[0];
    tready_v[0] = 1'b0;
    cs_low(0);
    for (int k = 1; k <= 6; k++) send_bits(0, 32'(k), 8);
    cs_high(0);
    check("ovr_level_lit",   32'(level_a[0]), 4);
    check("ovr_flag_lit",    32'(ovr_v[0]),   1);
    check("ovr_head_stable", 32'(tdata_a[0]), 32'h01);
    check("ovr_tvalid",      32'(tvalid_v[0]), 1);
    check_flags(0, "ovr");
    tready_v[0] = 1'b1;
    waitn(8);
    check("ovr_drain_beats", 32'(beats[0] - b0), 4);
    check("ovr_drain_last",  32'(last_data[0]), 32'h04);
    check("ovr_drain_level", 32'(level_a[0]), 0);
    pulse_clear(0);
    check("ovr_cleared", 32'(ovr_v[0]), 0);

    // Framing error: 5 bits then cs_n high, then a full byte.
    b0 = beats[0];
    cs_low(0);
    send_bits(0, 32'h16, 5);
    cs_high(0);
    cs_low(0);
    send_bits(0, 32'h5A, 8);
    cs_high(0);
    check("ferr_flag_lit", 32'(ferr_v[0]), 1);
    check("ferr_beats",    32'(beats[0] - b0), 1);
    check("ferr_data",     32'(last_data[0]), 32'h5A);
    check_flags(0, "ferr");
    pulse_clear(0);
    check("ferr_cleared", 32'(ferr_v[0]), 0);

    // Reset mid-frame with cs_n held low: no word until cs_n toggles.
    b0 = beats[0];
    cs_low(0);
    send_bits(0, 32'h5, 3);
    do_reset();
    send_bits(0, 32'hFF, 8);
    waitn(2*H);
    check("midrst_no_beat", 32'(beats[0] - b0), 0);
    check("midrst_state",   32'(st_a[0]), 32'(ST_WAIT_IDLE));
    check_flags(0, "midrst");
    cs_high(0);
    cs_low(0);
    send_bits(0, 32'h77, 8);
    cs_high(0);
    check("midrst_beat_after", 32'(beats[0] - b0), 1);
    check("midrst_data",       32'(last_data[0]), 32'h77);
    check_flags(0, "post");

    check("exp_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
